// File: rtl/pulse_train_gen.sv
// Triggered pulse-train generator: after a one-cycle trigger, waits a
// programmable delay and then emits npulses pulses of programmable width and
// spacing. It reports busy while a burst runs and gives a one-cycle done
// pulse at completion.
module pulse_train_gen #(
  parameter int unsigned TW = 16,
  parameter int unsigned NW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig,
  input  logic          abort,
  input  logic [TW-1:0] delay,
  input  logic [TW-1:0] width,
  input  logic [TW-1:0] period,
  input  logic [NW-1:0] npulses,
  output logic          pulse_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  // One-cycle gap between acceptance and the start of the burst, so that
  // busy and the first rise land one edge after the accepting edge.
  logic          arm_q, arm_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] rem_q, rem_d;
  logic [TW-1:0] delay_q, delay_d;
  logic [TW-1:0] width_q, width_d;
  logic [TW-1:0] lowlen_q, lowlen_d;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          finish_c;
  logic          accept_c;
  logic [TW-1:0] lowlen_c;

  // Low time between pulses. When period <= width the effective period is
  // width+1, i.e. a single low cycle; taking that branch directly avoids ever
  // forming width+1, which would overflow TW bits at width = 2^TW-1.
  always_comb begin
    if (period > width) begin
      lowlen_c = period - width;
    end else begin
      lowlen_c = TW'(1);
    end
  end

  // Burst ends on this edge: last cycle of the last pulse.
  assign finish_c = (state_q == HIGH) && (cnt_q == TW'(1)) && (rem_q == NW'(1));

  // A trigger is taken when idle, or on the very edge the previous burst ends.
  assign accept_c = trig && !abort && (npulses != '0) && (width != '0) &&
                    (((state_q == IDLE) && !arm_q) || finish_c);

  // Next-state, counter and output logic.
  always_comb begin
    state_d  = state_q;
    arm_d    = 1'b0;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    delay_d  = delay_q;
    width_d  = width_q;
    lowlen_d = lowlen_q;
    done_d   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_q) begin
            if (delay_q == '0) begin
              state_d = HIGH;
              cnt_d   = width_q;
            end else begin
              state_d = DELAY;
              cnt_d   = delay_q;
            end
          end
        end
        DELAY: begin
          if (cnt_q == TW'(1)) begin
            state_d = HIGH;
            cnt_d   = width_q;
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        HIGH: begin
          if (cnt_q == TW'(1)) begin
            if (rem_q == NW'(1)) begin
              state_d = IDLE;
              cnt_d   = '0;
              rem_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = LOW;
              cnt_d   = lowlen_q;
            end
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        LOW: begin
          if (cnt_q == TW'(1)) begin
            state_d = HIGH;
            cnt_d   = width_q;
            rem_d   = rem_q - NW'(1);
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (accept_c) begin
        arm_d    = 1'b1;
        delay_d  = delay;
        width_d  = width;
        lowlen_d = lowlen_c;
        rem_d    = npulses;
      end
    end

    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  // State, counters, latched settings and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      arm_q    <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      delay_q  <= '0;
      width_q  <= '0;
      lowlen_q <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      lowlen_q <= lowlen_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed scenarios plus random traffic, checked
// against a burst model that predicts outputs from rise times and windows.
module tb_pulse_train_gen;

  localparam int unsigned TW = 16;
  localparam int unsigned NW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] delay = '0;
  logic [TW-1:0] width = '0;
  logic [TW-1:0] period = '0;
  logic [NW-1:0] npulses = '0;
  logic          pulse_out;
  logic          busy;
  logic          done;

  pulse_train_gen #(.TW(TW), .NW(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .abort    (abort),
    .delay    (delay),
    .width    (width),
    .period   (period),
    .npulses  (npulses),
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: one burst described by its acceptance edge and settings.
  longint t = 0;
  bit     m_active = 1'b0;
  longint m_k, m_d, m_w, m_peff, m_np, m_end;
  logic [2:0] exp_v;  // {pulse_out, busy, done}

  // Predict outputs at edge t from the sampled inputs.
  task automatic model_edge();
    longint r0;
    exp_v = 3'b000;
    if (abort) begin
      m_active = 1'b0;
    end else begin
      if (m_active) begin
        r0 = m_k + 1 + m_d;
        exp_v[1] = (t >= m_k + 1) && (t < m_end);
        exp_v[0] = (t == m_end);
        exp_v[2] = (t >= r0) && (t < m_end) && (((t - r0) % m_peff) < m_w);
        if (t >= m_end) m_active = 1'b0;
      end
      if (trig && (npulses != 0) && (width != 0) && !m_active) begin
        m_k      = t;
        m_d      = longint'(delay);
        m_w      = longint'(width);
        m_peff   = (period > width) ? longint'(period) : longint'(width) + 1;
        m_np     = longint'(npulses);
        m_end    = t + 1 + m_d + (m_np - 1) * m_peff + m_w;
        m_active = 1'b1;
      end
    end
  endtask

  // Advance one clock, update the model, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    t++;
    model_edge();
    #1;
  endtask

  task automatic set_params(input int d, input int w, input int p, input int n);
    delay   = TW'(d);
    width   = TW'(w);
    period  = TW'(p);
    npulses = NW'(n);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({pulse_out, busy, done} !== 3'b000)
      $display("FAIL reset got=%b exp=000", {pulse_out, busy, done});
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL reset_idle t=%0d got=%b exp=%b", t, {pulse_out, busy, done}, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_nominal();
    int pcnt = 0;
    int dcnt = 0;
    int first_rise = -1;
    set_params(3, 2, 5, 3);
    for (int i = 0; i < 30; i++) begin
      trig = (i == 0);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL nominal i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
      pcnt += int'(pulse_out);
      dcnt += int'(done);
      if (pulse_out && first_rise < 0) first_rise = i;
    end
    trig = 1'b0;
    n_checks++;
    if (first_rise !== 4) $display("FAIL nominal_first_rise got=%0d exp=4", first_rise);
    else n_pass++;
    n_checks++;
    if (pcnt !== 6) $display("FAIL nominal_high_cycles got=%0d exp=6", pcnt);
    else n_pass++;
    n_checks++;
    if (dcnt !== 1) $display("FAIL nominal_done_count got=%0d exp=1", dcnt);
    else n_pass++;
  endtask

  task automatic test_period_le_width();
    logic [3:0] seen;
    set_params(0, 4, 2, 2);
    for (int i = 0; i < 14; i++) begin
      trig = (i == 0);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL peff i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
      if (i == 1)  seen[0] = pulse_out;
      if (i == 5)  seen[1] = pulse_out;
      if (i == 6)  seen[2] = pulse_out;
      if (i == 10) seen[3] = done;
    end
    trig = 1'b0;
    n_checks++;
    if (seen !== 4'b1101) $display("FAIL peff_edges got=%b exp=1101", seen);
    else n_pass++;
  endtask

  task automatic test_degenerate();
    int act = 0;
    for (int i = 0; i < 20; i++) begin
      trig = (i == 0) || (i == 6);
      if (i == 0) set_params(2, 3, 5, 0);
      if (i == 6) set_params(2, 0, 5, 3);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL degenerate i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
      act += int'(pulse_out | busy | done);
    end
    trig = 1'b0;
    n_checks++;
    if (act !== 0) $display("FAIL degenerate_activity got=%0d exp=0", act);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic b17 = 1'b0;
    set_params(3, 2, 5, 3);
    for (int i = 0; i < 40; i++) begin
      trig = (i == 0) || (i == 6) || (i == 16);
      if (i == 6) set_params(0, 7, 9, 5);
      if (i == 8) set_params(3, 2, 5, 3);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL back_to_back i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
      if (i == 17) b17 = busy;
    end
    trig = 1'b0;
    n_checks++;
    if (b17 !== 1'b1) $display("FAIL retrigger_busy got=%b exp=1", b17);
    else n_pass++;
  endtask

  task automatic test_abort();
    int dcnt = 0;
    set_params(3, 2, 5, 3);
    for (int i = 0; i < 20; i++) begin
      trig  = (i == 0);
      abort = (i == 5);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL abort i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
      dcnt += int'(done);
    end
    n_checks++;
    if (dcnt !== 0) $display("FAIL abort_done got=%0d exp=0", dcnt);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      trig  = (i == 0);
      abort = (i == 0);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL abort_trig i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
    end
    trig  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    set_params(1, 8, 12, 2);
    for (int i = 0; i < 5; i++) begin
      trig = (i == 0);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL pre_reset i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
    end
    trig = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    n_checks++;
    if ({pulse_out, busy, done} !== 3'b000)
      $display("FAIL async_reset got=%b exp=000", {pulse_out, busy, done});
    else n_pass++;
    set_params(0, 2, 3, 4);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL post_reset i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_input_change();
    set_params(2, 3, 6, 3);
    for (int i = 0; i < 25; i++) begin
      trig = (i == 0);
      if (i == 3) set_params(0, 1, 2, 7);
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL input_change i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
    end
    trig = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      trig  = ($urandom_range(0, 4) == 0);
      abort = ($urandom_range(0, 80) == 0);
      if ($urandom_range(0, 3) == 0)
        set_params(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 9)), int'($urandom_range(0, 4)));
      tick();
      n_checks++;
      if ({pulse_out, busy, done} !== exp_v)
        $display("FAIL random i=%0d got=%b exp=%b", i, {pulse_out, busy, done}, exp_v);
      else n_pass++;
    end
    trig  = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_period_le_width();
    test_degenerate();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_input_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
